fc_l2_port_arbiter: RTL and testbench
=====================================

// Module: fc_l2_port_arbiter
// PURPOSE
// - Shares one TCDM-style L2 master port (req/gnt, in-order r_valid) among N_MASTERS requesters.
// - Typical requesters: FC core data port, a debug/DMA master and the datalynx dump engine,
//   all in the fc_subsystem.
// - Round-robin arbitration with a winner lock while a request is stalled. An ID FIFO
//   records each granted request so that every response goes back to the master that issued it.
// PARAMETERS
// N_MASTERS   2   number of requesters (>=2)
// MAX_OUTST   4   max granted-but-unanswered transactions (power of 2, >=1)
// ADDR_WIDTH  32  address width
// DATA_WIDTH  32  data width; byte-enable width is DATA_WIDTH/8
// PORTS
// clk_i            in   1                   clock
// rst_ni           in   1                   async active-low reset
// in_req_i         in   N                   per-master request
// in_add_i         in   N x ADDR_WIDTH      per-master address
// in_wen_i         in   N                   per-master write-enable-n (1 = read)
// in_wdata_i       in   N x DATA_WIDTH      per-master write data
// in_be_i          in   N x DATA_WIDTH/8    per-master byte enables
// in_gnt_o         out  N                   per-master grant
// in_r_valid_o     out  N                   per-master response valid
// in_r_rdata_o     out  DATA_WIDTH          response data, broadcast to all masters
// in_r_opc_o       out  1                   response error, broadcast to all masters
// out_req_o        out  1                   L2 request
// out_add_o        out  ADDR_WIDTH          L2 address
// out_wen_o        out  1                   L2 write-enable-n
// out_wdata_o      out  DATA_WIDTH          L2 write data
// out_be_o         out  DATA_WIDTH/8        L2 byte enables
// out_gnt_i        in   1                   L2 grant
// out_r_valid_i    in   1                   L2 response valid (in order)
// out_r_rdata_i    in   DATA_WIDTH          L2 response data
// out_r_opc_i      in   1                   L2 response error
// outstanding_o    out  $clog2(MAX_OUTST+1) number of in-flight transactions
// protocol_err_o   out  1                   sticky flag: response received with no outstanding transaction
// BEHAVIOUR
// - Single clock clk_i. Reset is asynchronous, active-low on rst_ni.
// - Reset values:
//   - Registered outputs: outstanding_o = 0, protocol_err_o = 0.
//   - Internal state: FIFO empty, lock cleared, RR pointer = 0.
//   - Combinational outputs are 0 whenever no in_req_i bit is set.
// - Winner selection:
//   - If lock is valid, winner = locked index.
//   - Otherwise winner = first requesting master at or after the RR pointer, searching
//     cyclically (ptr, ptr+1, ... mod N).
// - Issue condition:
//   - out_req_o = (any in_req_i) && (count < MAX_OUTST).
//   - A response arriving in the same cycle does NOT free a slot, so there is no
//     comb path from r_valid to req.
// - Payload: out_add/wen/wdata/be come from the winner; all 0 when out_req_o = 0.
// - Grant: in_gnt_o[k] = out_gnt_i && out_req_o && (winner == k). Zero-cycle forward.
// - Lock:
//   - Set when out_req_o && !out_gnt_i: lock = winner.
//   - Cleared on the handshake.
//   - Masters hold req and payload until gnt (TCDM rule). A locked master dropping req
//     clears the lock in the next cycle.
// - On handshake (out_req_o && out_gnt_i):
//   - Push the winner index into the ID FIFO.
//   - RR pointer = (winner + 1) mod N.
// - Response routing:
//   - When out_r_valid_i is high and the FIFO is non-empty: pop, and set
//     in_r_valid_o[head] = 1 in the same cycle.
//   - rdata and opc are forwarded unregistered.
// - Response with an empty FIFO:
//   - No in_r_valid_o is asserted.
//   - protocol_err_o sets and stays set until reset.
// - Simultaneous push and pop: count unchanged, FIFO pointers wrap modulo MAX_OUTST.
// - Reset while transactions are outstanding discards all state. Late responses then hit
//   the empty-FIFO rule.
// STRUCTURE
// - Package fc_l2_arb_pkg holds:
//   - the master index typedef (logic [$clog2(N_MASTERS)-1:0]);
//   - the count typedef;
//   - the function rr_pick(req, ptr).
// - Sub-module fc_l2_arb_id_fifo: synchronous FIFO of master indices, depth MAX_OUTST,
//   with push, pop, full, empty, count and head ports.
// - Top level contains the RR pointer, lock register, muxes, response demux and error flag.
// TESTING (N_MASTERS=2, MAX_OUTST=4 unless stated)
// 1. Single read, 1-cycle latency:
//    - Stimulus: m0 requests add=0x1C000100 wen=1; out_gnt_i=1; next cycle r_valid with
//      rdata=0xDEADBEEF.
//    - Response: in_gnt_o=01, in_r_valid_o=01 for one cycle, outstanding_o goes 1 -> 0.
// 2. Round-robin fairness:
//    - Stimulus: m0 and m1 request continuously; gnt and r_valid tied to 1.
//    - Response: grants alternate 0,1,0,1,...; responses route in the same order; no
//      master granted twice in a row.
// 3. Stall lock:
//    - Stimulus: m0 requests with out_gnt_i=0 for 3 cycles; m1 raises req in cycle 2.
//    - Response: out_add_o stays m0's address; the first gnt goes to m0, the next to m1.
// 4. Outstanding limit:
//    - Stimulus: four grants with no responses.
//    - Response: outstanding_o=4 and out_req_o=0 while m0 still requests. One r_valid
//      arrives -> out_req_o returns in the following cycle and the grant is accepted.
// 5. Spurious response:
//    - Stimulus: out_r_valid_i=1 with an empty FIFO.
//    - Response: in_r_valid_o=00, protocol_err_o=1 and held for 10+ cycles.
// 6. Reset mid-flight:
//    - Stimulus: 3 outstanding, then rst_ni pulsed low.
//    - Response: outstanding_o=0, next grant goes to m0 when both request, and a late
//      r_valid sets protocol_err_o.

Source files
------------

// File: rtl/fc_l2_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : fc_l2_arb_pkg
// Brief  : Shared configuration, index/count types and round-robin helper
//          for the fc_subsystem L2 port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package fc_l2_arb_pkg;

    // Arbiter configuration; the types below are sized from these values.
    localparam int unsigned ARB_N_MASTERS = 2;
    localparam int unsigned ARB_MAX_OUTST = 4;
    localparam int unsigned ARB_IDX_W     = (ARB_N_MASTERS > 1) ? $clog2(ARB_N_MASTERS) : 1;
    localparam int unsigned ARB_CNT_W     = $clog2(ARB_MAX_OUTST + 1);

    typedef logic [ARB_IDX_W-1:0] mst_idx_t;
    typedef logic [ARB_CNT_W-1:0] cnt_t;

    // Scans downward so the candidate closest to ptr is the last one written.
    function automatic mst_idx_t rr_pick(input logic [ARB_N_MASTERS-1:0] req,
                                         input mst_idx_t                 ptr);
        mst_idx_t idx;
        rr_pick = ptr;
        for (int i = ARB_N_MASTERS - 1; i >= 0; i--) begin
            idx = mst_idx_t'((int'(ptr) + i) % ARB_N_MASTERS);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_l2_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module : fc_l2_arb_id_fifo
// Brief  : Synchronous FIFO of granted master indices, used to route the
//          in-order L2 responses back to their issuers.
// Rev    : 1.0 - initial release
// ============================================================================
module fc_l2_arb_id_fifo
    import fc_l2_arb_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     i_push,
    input  mst_idx_t i_push_idx,
    input  logic     i_pop,
    output mst_idx_t o_head,
    output logic     o_full,
    output logic     o_empty,
    output cnt_t     o_count
);

    localparam int unsigned PTR_W = (ARB_MAX_OUTST > 1) ? $clog2(ARB_MAX_OUTST) : 1;

    mst_idx_t          r_mem [ARB_MAX_OUTST];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    cnt_t              r_count;
    logic              w_push;
    logic              w_pop;

    // Explicit wrap keeps non-power-of-two depths legal as well.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(ARB_MAX_OUTST - 1)) ptr_inc = '0;
        else                                ptr_inc = p + 1'b1;
    endfunction

    assign o_full  = (r_count == cnt_t'(ARB_MAX_OUTST));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fc_l2_port_arbiter
// Brief  : Round-robin arbiter sharing one TCDM-style L2 port among several
//          masters, with stall lock and in-order response routing.
// Rev    : 1.0 - initial release
// ============================================================================
module fc_l2_port_arbiter
    import fc_l2_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS  = ARB_N_MASTERS,
    parameter int unsigned MAX_OUTST  = ARB_MAX_OUTST,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [N_MASTERS-1:0]              in_req_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]   in_add_i,
    input  logic [N_MASTERS-1:0]              in_wen_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]   in_wdata_i,
    input  logic [N_MASTERS*DATA_WIDTH/8-1:0] in_be_i,
    output logic [N_MASTERS-1:0]              in_gnt_o,
    output logic [N_MASTERS-1:0]              in_r_valid_o,
    output logic [DATA_WIDTH-1:0]             in_r_rdata_o,
    output logic                              in_r_opc_o,
    output logic                              out_req_o,
    output logic [ADDR_WIDTH-1:0]             out_add_o,
    output logic                              out_wen_o,
    output logic [DATA_WIDTH-1:0]             out_wdata_o,
    output logic [DATA_WIDTH/8-1:0]           out_be_o,
    input  logic                              out_gnt_i,
    input  logic                              out_r_valid_i,
    input  logic [DATA_WIDTH-1:0]             out_r_rdata_i,
    input  logic                              out_r_opc_i,
    output logic [$clog2(MAX_OUTST+1)-1:0]    outstanding_o,
    output logic                              protocol_err_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    mst_idx_t r_rr_ptr;
    mst_idx_t r_lock_idx;
    logic     r_lock_vld;
    logic     r_prot_err;

    mst_idx_t w_winner;
    mst_idx_t w_rr_next;
    mst_idx_t w_head;
    cnt_t     w_count;
    logic     w_lock_hold;
    logic     w_handshake;
    logic     w_pop;
    logic     w_fifo_full;
    logic     w_fifo_empty;

    // A lock only holds while its owner keeps requesting.
    assign w_lock_hold  = r_lock_vld && in_req_i[r_lock_idx];
    assign w_winner     = w_lock_hold ? r_lock_idx : rr_pick(in_req_i, r_rr_ptr);
    assign w_rr_next    = (w_winner == mst_idx_t'(N_MASTERS - 1)) ? '0 : w_winner + 1'b1;

    // Full is judged on registered count only: no r_valid -> req path.
    assign out_req_o    = (|in_req_i) && !w_fifo_full;
    assign w_handshake  = out_req_o && out_gnt_i;
    assign w_pop        = out_r_valid_i && !w_fifo_empty;

    assign in_r_rdata_o   = out_r_rdata_i;
    assign in_r_opc_o     = out_r_opc_i;
    assign outstanding_o  = w_count;
    assign protocol_err_o = r_prot_err;

    always_comb begin
        out_add_o    = '0;
        out_wen_o    = 1'b0;
        out_wdata_o  = '0;
        out_be_o     = '0;
        in_gnt_o     = '0;
        in_r_valid_o = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (out_req_o && (w_winner == mst_idx_t'(k))) begin
                out_add_o   = in_add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                out_wen_o   = in_wen_i[k];
                out_wdata_o = in_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                out_be_o    = in_be_i[k*BE_WIDTH +: BE_WIDTH];
                in_gnt_o[k] = out_gnt_i;
            end
            in_r_valid_o[k] = w_pop && (w_head == mst_idx_t'(k));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_lock_vld <= 1'b0;
            r_prot_err <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_rr_ptr   <= w_rr_next;
                r_lock_vld <= 1'b0;
            end else if (out_req_o) begin
                r_lock_vld <= 1'b1;
                r_lock_idx <= w_winner;
            end else if (r_lock_vld && !in_req_i[r_lock_idx]) begin
                r_lock_vld <= 1'b0;
            end
            if (out_r_valid_i && w_fifo_empty) r_prot_err <= 1'b1;
        end
    end

    fc_l2_arb_id_fifo u_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_push     (w_handshake),
        .i_push_idx (w_winner),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fc_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fc_l2_port_arbiter
// Brief  : Directed self-checking bench for fc_l2_port_arbiter (2 masters,
//          4 outstanding).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fc_l2_port_arbiter;

    localparam logic [31:0] A0 = 32'h1C00_0100;
    localparam logic [31:0] A1 = 32'h1C00_0200;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  in_req_i;
    logic [63:0] in_add_i;
    logic [1:0]  in_wen_i;
    logic [63:0] in_wdata_i;
    logic [7:0]  in_be_i;
    logic [1:0]  in_gnt_o;
    logic [1:0]  in_r_valid_o;
    logic [31:0] in_r_rdata_o;
    logic        in_r_opc_o;
    logic        out_req_o;
    logic [31:0] out_add_o;
    logic        out_wen_o;
    logic [31:0] out_wdata_o;
    logic [3:0]  out_be_o;
    logic        out_gnt_i;
    logic        out_r_valid_i;
    logic [31:0] out_r_rdata_i;
    logic        out_r_opc_i;
    logic [2:0]  outstanding_o;
    logic        protocol_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fc_l2_port_arbiter #(
        .N_MASTERS(2), .MAX_OUTST(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .in_req_i(in_req_i), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
        .in_wdata_i(in_wdata_i), .in_be_i(in_be_i),
        .in_gnt_o(in_gnt_o), .in_r_valid_o(in_r_valid_o),
        .in_r_rdata_o(in_r_rdata_o), .in_r_opc_o(in_r_opc_o),
        .out_req_o(out_req_o), .out_add_o(out_add_o), .out_wen_o(out_wen_o),
        .out_wdata_o(out_wdata_o), .out_be_o(out_be_o),
        .out_gnt_i(out_gnt_i), .out_r_valid_i(out_r_valid_i),
        .out_r_rdata_i(out_r_rdata_i), .out_r_opc_i(out_r_opc_i),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_req_i      = 2'b00;
        in_add_i      = {A1, A0};
        in_wen_i      = 2'b11;
        in_wdata_i    = '0;
        in_be_i       = 8'hFF;
        out_gnt_i     = 1'b0;
        out_r_valid_i = 1'b0;
        out_r_rdata_i = '0;
        out_r_opc_i   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        @(negedge clk);
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
        n_checks++; if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_prot_err: got %b want 0", protocol_err_o); end
        tick();
        rst_ni = 1'b1;
        @(negedge clk);
        n_checks++; if ({out_req_o, in_gnt_o, in_r_valid_o} !== 5'b0) begin n_fail++; $display("FAIL idle_ctrl: got %b want 00000", {out_req_o, in_gnt_o, in_r_valid_o}); end
        n_checks++; if ({out_add_o, out_wen_o, out_be_o} !== 37'b0) begin n_fail++; $display("FAIL idle_payload: got %h want 0", {out_add_o, out_wen_o, out_be_o}); end
    endtask

    task automatic test_single_read();
        do_reset();
        in_req_i = 2'b01; out_gnt_i = 1'b1;
        @(negedge clk);
        n_checks++; if (in_gnt_o !== 2'b01) begin n_fail++; $display("FAIL read_gnt: got %b want 01", in_gnt_o); end
        n_checks++; if ({out_req_o, out_add_o, out_wen_o} !== {1'b1, A0, 1'b1}) begin n_fail++; $display("FAIL read_payload: got req=%b add=%h wen=%b", out_req_o, out_add_o, out_wen_o); end
        tick();
        in_req_i = 2'b00; out_gnt_i = 1'b0; out_r_valid_i = 1'b1; out_r_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if (outstanding_o !== 3'd1) begin n_fail++; $display("FAIL read_outst1: got %0d want 1", outstanding_o); end
        n_checks++; if ({in_r_valid_o, in_r_rdata_o} !== {2'b01, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL read_resp: got %b %h want 01 deadbeef", in_r_valid_o, in_r_rdata_o); end
        tick();
        out_r_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if ({outstanding_o, in_r_valid_o} !== 5'b0) begin n_fail++; $display("FAIL read_done: got outst=%0d rv=%b want 0 00", outstanding_o, in_r_valid_o); end
    endtask

    task automatic test_write_payload();
        do_reset();
        in_req_i   = 2'b10; in_wen_i = 2'b01; out_gnt_i = 1'b1;
        in_wdata_i = {32'hA5A5_5A5A, 32'h1111_2222}; in_be_i = 8'hC3;
        @(negedge clk);
        n_checks++; if (in_gnt_o !== 2'b10) begin n_fail++; $display("FAIL wr_gnt: got %b want 10", in_gnt_o); end
        n_checks++; if ({out_add_o, out_wen_o, out_wdata_o, out_be_o} !== {A1, 1'b0, 32'hA5A5_5A5A, 4'hC}) begin n_fail++; $display("FAIL wr_payload: got add=%h wen=%b wd=%h be=%h", out_add_o, out_wen_o, out_wdata_o, out_be_o); end
        tick();
        in_req_i = 2'b00; out_gnt_i = 1'b0; out_r_valid_i = 1'b1; out_r_opc_i = 1'b1;
        @(negedge clk);
        n_checks++; if ({in_r_valid_o, in_r_opc_o} !== 3'b101) begin n_fail++; $display("FAIL wr_resp: got rv=%b opc=%b want 10 1", in_r_valid_o, in_r_opc_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt;
        logic [1:0] exp_rv;
        do_reset();
        in_req_i = 2'b11; out_gnt_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            out_r_valid_i = (i > 0);
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_rv  = (i == 0) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
            n_checks++; if (in_gnt_o !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, in_gnt_o, exp_gnt); end
            n_checks++; if (out_add_o !== ((i % 2 == 0) ? A0 : A1)) begin n_fail++; $display("FAIL rr_add[%0d]: got %h", i, out_add_o); end
            n_checks++; if (in_r_valid_o !== exp_rv) begin n_fail++; $display("FAIL rr_rv[%0d]: got %b want %b", i, in_r_valid_o, exp_rv); end
            tick();
        end
        in_req_i = 2'b00; out_gnt_i = 1'b0;
        @(negedge clk);
        n_checks++; if (in_r_valid_o !== 2'b10) begin n_fail++; $display("FAIL rr_last_rv: got %b want 10", in_r_valid_o); end
        tick();
        out_r_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if ({outstanding_o, protocol_err_o} !== 4'b0) begin n_fail++; $display("FAIL rr_end: got outst=%0d err=%b want 0 0", outstanding_o, protocol_err_o); end
    endtask

    task automatic test_stall_lock();
        do_reset();
        // One m0 transaction first so the RR pointer favours m1.
        in_req_i = 2'b01; out_gnt_i = 1'b1;
        tick();
        in_req_i = 2'b00; out_gnt_i = 1'b0; out_r_valid_i = 1'b1;
        tick();
        out_r_valid_i = 1'b0; in_req_i = 2'b01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if ({in_gnt_o, out_add_o} !== {2'b00, A0}) begin n_fail++; $display("FAIL lock_stall[%0d]: got gnt=%b add=%h want 00 %h", c, in_gnt_o, out_add_o, A0); end
            tick();
            in_req_i = 2'b11;
        end
        out_gnt_i = 1'b1;
        @(negedge clk);
        n_checks++; if ({in_gnt_o, out_add_o} !== {2'b01, A0}) begin n_fail++; $display("FAIL lock_first: got gnt=%b add=%h want 01 %h", in_gnt_o, out_add_o, A0); end
        tick();
        in_req_i = 2'b10;
        @(negedge clk);
        n_checks++; if ({in_gnt_o, out_add_o} !== {2'b10, A1}) begin n_fail++; $display("FAIL lock_second: got gnt=%b add=%h want 10 %h", in_gnt_o, out_add_o, A1); end
        tick();
        in_req_i = 2'b00; out_gnt_i = 1'b0; out_r_valid_i = 1'b1;
        @(negedge clk);
        n_checks++; if (in_r_valid_o !== 2'b01) begin n_fail++; $display("FAIL lock_rv0: got %b want 01", in_r_valid_o); end
        tick();
        @(negedge clk);
        n_checks++; if (in_r_valid_o !== 2'b10) begin n_fail++; $display("FAIL lock_rv1: got %b want 10", in_r_valid_o); end
        tick();
        out_r_valid_i = 1'b0;
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        in_req_i = 2'b01; out_gnt_i = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        n_checks++; if (outstanding_o !== 3'd4) begin n_fail++; $display("FAIL lim_outst4: got %0d want 4", outstanding_o); end
        n_checks++; if ({out_req_o, in_gnt_o} !== 3'b000) begin n_fail++; $display("FAIL lim_blocked: got req=%b gnt=%b want 0 00", out_req_o, in_gnt_o); end
        tick();
        out_r_valid_i = 1'b1;
        @(negedge clk);
        n_checks++; if ({out_req_o, in_r_valid_o} !== 3'b001) begin n_fail++; $display("FAIL lim_same_cycle: got req=%b rv=%b want 0 01", out_req_o, in_r_valid_o); end
        tick();
        out_r_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_req_o, in_gnt_o, outstanding_o} !== {1'b1, 2'b01, 3'd3}) begin n_fail++; $display("FAIL lim_resume: got req=%b gnt=%b outst=%0d want 1 01 3", out_req_o, in_gnt_o, outstanding_o); end
        tick();
        in_req_i = 2'b00; out_gnt_i = 1'b0; out_r_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (in_r_valid_o !== 2'b01) begin n_fail++; $display("FAIL lim_drain[%0d]: got %b want 01", i, in_r_valid_o); end
            tick();
        end
        out_r_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if ({outstanding_o, protocol_err_o} !== 4'b0) begin n_fail++; $display("FAIL lim_end: got outst=%0d err=%b want 0 0", outstanding_o, protocol_err_o); end
    endtask

    task automatic test_spurious();
        do_reset();
        out_r_valid_i = 1'b1;
        @(negedge clk);
        n_checks++; if ({in_r_valid_o, protocol_err_o} !== 3'b000) begin n_fail++; $display("FAIL spur_cycle: got rv=%b err=%b want 00 0", in_r_valid_o, protocol_err_o); end
        tick();
        out_r_valid_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_checks++; if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL spur_sticky[%0d]: got %b want 1", i, protocol_err_o); end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        in_req_i = 2'b01; out_gnt_i = 1'b1;
        repeat (3) tick();
        in_req_i = 2'b00; out_gnt_i = 1'b0;
        @(negedge clk);
        n_checks++; if (outstanding_o !== 3'd3) begin n_fail++; $display("FAIL mid_outst3: got %0d want 3", outstanding_o); end
        tick();
        rst_ni = 1'b0;
        #1;
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL mid_async_clear: got %0d want 0", outstanding_o); end
        tick();
        rst_ni = 1'b1; out_r_valid_i = 1'b1;
        @(negedge clk);
        n_checks++; if (in_r_valid_o !== 2'b00) begin n_fail++; $display("FAIL mid_late_rv: got %b want 00", in_r_valid_o); end
        tick();
        out_r_valid_i = 1'b0; in_req_i = 2'b11; out_gnt_i = 1'b1;
        @(negedge clk);
        n_checks++; if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL mid_prot_err: got %b want 1", protocol_err_o); end
        n_checks++; if (in_gnt_o !== 2'b01) begin n_fail++; $display("FAIL mid_gnt_m0: got %b want 01", in_gnt_o); end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_payload();
        test_round_robin();
        test_stall_lock();
        test_outstanding_limit();
        test_spurious();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
